vector_exec_unit: RTL and testbench

Parametrised multicycle vector execution unit for the single-cycle ARM core. It holds its own vector register file, with NVREG registers of VLEN elements each, WIDTH bits per element. It executes element-wise vector-vector and vector-scalar ALU ops, plus a vector sum reduction, processing LANES elements per cycle. The core datapath starts an op with a start/ready handshake and stalls until done. It loads and inspects elements through a scalar side port.

---
 rtl/vector_exec_unit_if.sv | 40 ++++
 rtl/vector_exec_unit.sv | 132 +++++++++++++
 tb/tb_vector_exec_unit.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_exec_unit_if.sv
// rtl/vector_exec_unit_if.sv - core-side bundle for the vector execution unit
interface vector_exec_unit_if #(
    parameter int WIDTH = 32,
    parameter int VLEN  = 5,
    parameter int NVREG = 16
);
    localparam int AW = (NVREG > 1) ? $clog2(NVREG) : 1;
    localparam int EW = (VLEN > 1) ? $clog2(VLEN) : 1;

    logic             start;
    logic [2:0]       op;
    logic             vv;
    logic [AW-1:0]    vs1;
    logic [AW-1:0]    vs2;
    logic [AW-1:0]    vd;
    logic [WIDTH-1:0] scalar;
    logic             ld_we;
    logic [AW-1:0]    ld_vreg;
    logic [EW-1:0]    ld_elem;
    logic [WIDTH-1:0] ld_data;
    logic [AW-1:0]    rd_vreg;
    logic [EW-1:0]    rd_elem;
    logic [WIDTH-1:0] rd_data;
    logic             ready;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] red_result;

    modport master (
        output start, op, vv, vs1, vs2, vd, scalar,
        output ld_we, ld_vreg, ld_elem, ld_data, rd_vreg, rd_elem,
        input  rd_data, ready, done, err, red_result
    );

    modport slave (
        input  start, op, vv, vs1, vs2, vd, scalar,
        input  ld_we, ld_vreg, ld_elem, ld_data, rd_vreg, rd_elem,
        output rd_data, ready, done, err, red_result
    );
endinterface

// File: rtl/vector_exec_unit.sv
// rtl/vector_exec_unit.sv - multicycle vector ALU with private register file
// Processes LANES elements per EXEC beat; REDSUM accumulates into red_result.
module vector_exec_unit #(
    parameter int WIDTH = 32,
    parameter int VLEN  = 5,
    parameter int LANES = 1,
    parameter int NVREG = 16
) (
    input  logic                clk,
    input  logic                reset,
    vector_exec_unit_if.slave   bus
);
    localparam int AW = (NVREG > 1) ? $clog2(NVREG) : 1;
    localparam int EW = (VLEN > 1) ? $clog2(VLEN) : 1;
    localparam int IW = $clog2(VLEN + LANES + 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_RED = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t state, state_d;

    logic [NVREG-1:0][VLEN-1:0][WIDTH-1:0] vrf;

    logic [2:0]       op_q;
    logic             vv_q;
    logic [AW-1:0]    vs1_q, vs2_q, vd_q;
    logic [WIDTH-1:0] scalar_q;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] acc, acc_d;
    logic [WIDTH-1:0] red_q;
    logic             err_q;
    logic             last_beat;

    logic             lane_act  [LANES];
    logic [EW-1:0]    lane_elem [LANES];
    logic [WIDTH-1:0] lane_a    [LANES];
    logic [WIDTH-1:0] lane_b    [LANES];
    logic [WIDTH-1:0] lane_res  [LANES];

    // Masked lanes are steered to element 0 so every read stays in range.
    always_comb begin
        acc_d = acc;
        for (int l = 0; l < LANES; l++) begin
            lane_act[l]  = (int'(idx) + l) < VLEN;
            lane_elem[l] = lane_act[l] ? EW'(int'(idx) + l) : '0;
            lane_a[l]    = vrf[vs1_q][lane_elem[l]];
            lane_b[l]    = vv_q ? vrf[vs2_q][lane_elem[l]] : scalar_q;
            case (op_q)
                OP_ADD:  lane_res[l] = lane_a[l] + lane_b[l];
                OP_SUB:  lane_res[l] = lane_a[l] - lane_b[l];
                OP_AND:  lane_res[l] = lane_a[l] & lane_b[l];
                OP_OR:   lane_res[l] = lane_a[l] | lane_b[l];
                default: lane_res[l] = lane_a[l];
            endcase
            if (lane_act[l]) begin
                acc_d = acc_d + lane_a[l];
            end
        end
        last_beat = (int'(idx) + LANES) >= VLEN;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: if (bus.start) state_d = (bus.op > OP_RED) ? S_DONE : S_EXEC;
            S_EXEC: if (last_beat) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            vrf      <= '0;
            op_q     <= '0;
            vv_q     <= 1'b0;
            vs1_q    <= '0;
            vs2_q    <= '0;
            vd_q     <= '0;
            scalar_q <= '0;
            idx      <= '0;
            acc      <= '0;
            red_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_d;
            case (state)
                S_IDLE: begin
                    if (bus.ld_we && (int'(bus.ld_elem) < VLEN)) begin
                        vrf[bus.ld_vreg][bus.ld_elem] <= bus.ld_data;
                    end
                    if (bus.start) begin
                        op_q     <= bus.op;
                        vv_q     <= bus.vv;
                        vs1_q    <= bus.vs1;
                        vs2_q    <= bus.vs2;
                        vd_q     <= bus.vd;
                        scalar_q <= bus.scalar;
                        idx      <= '0;
                        acc      <= '0;
                        err_q    <= bus.op > OP_RED;
                    end
                end
                S_EXEC: begin
                    for (int l = 0; l < LANES; l++) begin
                        if (lane_act[l] && (op_q != OP_RED)) begin
                            vrf[vd_q][lane_elem[l]] <= lane_res[l];
                        end
                    end
                    idx <= idx + IW'(LANES);
                    acc <= acc_d;
                    if (last_beat && (op_q == OP_RED)) begin
                        red_q <= acc_d;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rd_data    = (int'(bus.rd_elem) < VLEN) ? vrf[bus.rd_vreg][bus.rd_elem] : '0;
    assign bus.ready      = (state == S_IDLE);
    assign bus.done       = (state == S_DONE);
    assign bus.err        = (state == S_DONE) && err_q;
    assign bus.red_result = red_q;
endmodule

// File: tb/tb_vector_exec_unit.sv
// tb/tb_vector_exec_unit.sv - bench driving LANES=1 and LANES=2 units in lockstep
module tb_vector_exec_unit;
    localparam int W  = 32;
    localparam int V  = 5;
    localparam int NV = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vector_exec_unit_if #(.WIDTH(W), .VLEN(V), .NVREG(NV)) b1 ();
    vector_exec_unit_if #(.WIDTH(W), .VLEN(V), .NVREG(NV)) b2 ();

    assign b2.start   = b1.start;
    assign b2.op      = b1.op;
    assign b2.vv      = b1.vv;
    assign b2.vs1     = b1.vs1;
    assign b2.vs2     = b1.vs2;
    assign b2.vd      = b1.vd;
    assign b2.scalar  = b1.scalar;
    assign b2.ld_we   = b1.ld_we;
    assign b2.ld_vreg = b1.ld_vreg;
    assign b2.ld_elem = b1.ld_elem;
    assign b2.ld_data = b1.ld_data;
    assign b2.rd_vreg = b1.rd_vreg;
    assign b2.rd_elem = b1.rd_elem;

    vector_exec_unit #(.WIDTH(W), .VLEN(V), .LANES(1), .NVREG(NV)) u_l1 (
        .clk(clk), .reset(rst_n), .bus(b1)
    );
    vector_exec_unit #(.WIDTH(W), .VLEN(V), .LANES(2), .NVREG(NV)) u_l2 (
        .clk(clk), .reset(rst_n), .bus(b2)
    );

    logic [31:0] mem [NV][V];
    logic [31:0] red_m;
    int vectors = 0;
    int miscompares = 0;

    task automatic model_clear();
        for (int r = 0; r < NV; r++) for (int e = 0; e < V; e++) mem[r][e] = '0;
        red_m = '0;
    endtask

    task automatic model_op(input logic [2:0] op, input logic vv, input int vs1, vs2, vd,
                            input logic [31:0] scalar);
        logic [31:0] a, b, s;
        if (op == 3'd4) begin
            s = 0;
            for (int e = 0; e < V; e++) s += mem[vs1][e];
            red_m = s;
        end else if (op < 3'd4) begin
            for (int e = 0; e < V; e++) begin
                a = mem[vs1][e];
                b = vv ? mem[vs2][e] : scalar;
                case (op)
                    3'd0: mem[vd][e] = a + b;
                    3'd1: mem[vd][e] = a - b;
                    3'd2: mem[vd][e] = a & b;
                    default: mem[vd][e] = a | b;
                endcase
            end
        end
    endtask

    task automatic idle_inputs();
        b1.start = 0; b1.op = 0; b1.vv = 0; b1.vs1 = 0; b1.vs2 = 0; b1.vd = 0;
        b1.scalar = 0; b1.ld_we = 0; b1.ld_vreg = 0; b1.ld_elem = 0; b1.ld_data = 0;
        b1.rd_vreg = 0; b1.rd_elem = 0;
    endtask

    task automatic load(input int vr, input int el, input logic [31:0] d);
        @(negedge clk);
        b1.ld_we = 1; b1.ld_vreg = vr[3:0]; b1.ld_elem = el[2:0]; b1.ld_data = d;
        @(negedge clk);
        b1.ld_we = 0;
        if (el < V) mem[vr][el] = d;
    endtask

    task automatic peek(input int vr, input int el, output logic [31:0] d1, output logic [31:0] d2);
        b1.rd_vreg = vr[3:0]; b1.rd_elem = el[2:0];
        #1;
        d1 = b1.rd_data; d2 = b2.rd_data;
    endtask

    task automatic run_op(input logic [2:0] op, input logic vv, input int vs1, vs2, vd,
                          input logic [31:0] scalar, input bit with_ld, input int lvr, lel,
                          input logic [31:0] ldd, input bit poke,
                          output int da1, da2, nd1, nd2, rl1, rl2, output logic e1, e2);
        da1 = 0; da2 = 0; nd1 = 0; nd2 = 0; rl1 = 0; rl2 = 0; e1 = 0; e2 = 0;
        @(negedge clk);
        b1.op = op; b1.vv = vv; b1.vs1 = vs1[3:0]; b1.vs2 = vs2[3:0]; b1.vd = vd[3:0];
        b1.scalar = scalar; b1.start = 1;
        if (with_ld) begin
            b1.ld_we = 1; b1.ld_vreg = lvr[3:0]; b1.ld_elem = lel[2:0]; b1.ld_data = ldd;
        end
        @(posedge clk);
        #1;
        b1.start = 0; b1.ld_we = 0;
        if (with_ld && lel < V) mem[lvr][lel] = ldd;
        model_op(op, vv, vs1, vs2, vd, scalar);
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (b1.done) begin nd1++; if (da1 == 0) begin da1 = n; e1 = b1.err; end end
            if (b2.done) begin nd2++; if (da2 == 0) begin da2 = n; e2 = b2.err; end end
            if (!b1.ready) rl1++;
            if (!b2.ready) rl2++;
            if (poke && n == 2) begin
                b1.start = 1; b1.op = 3'd0; b1.vd = 4'd0;
                b1.ld_we = 1; b1.ld_vreg = 4'd0; b1.ld_elem = 3'd0; b1.ld_data = 32'hDEADBEEF;
            end
            if (poke && n == 3) begin b1.start = 0; b1.ld_we = 0; end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d1, d2;
        idle_inputs();
        rst_n = 0;
        model_clear();
        repeat (2) @(negedge clk);
        vectors += 6;
        if (b1.ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready_l1: got %b want 1", b1.ready); end
        if (b2.ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready_l2: got %b want 1", b2.ready); end
        if (b1.done !== 1'b0) begin miscompares++; $display("FAIL reset_done_l1: got %b want 0", b1.done); end
        if (b2.done !== 1'b0) begin miscompares++; $display("FAIL reset_done_l2: got %b want 0", b2.done); end
        if (b1.red_result !== 32'd0) begin miscompares++; $display("FAIL reset_red_l1: got %h want 0", b1.red_result); end
        if (b2.red_result !== 32'd0) begin miscompares++; $display("FAIL reset_red_l2: got %h want 0", b2.red_result); end
        for (int r = 0; r < NV; r += 5) for (int e = 0; e < V; e++) begin
            peek(r, e, d1, d2);
            vectors += 2;
            if (d1 !== 32'd0) begin miscompares++; $display("FAIL reset_vrf_l1 v%0d[%0d]: got %h want 0", r, e, d1); end
            if (d2 !== 32'd0) begin miscompares++; $display("FAIL reset_vrf_l2 v%0d[%0d]: got %h want 0", r, e, d2); end
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_add();
        int da1, da2, nd1, nd2, rl1, rl2;
        logic e1, e2;
        logic [31:0] d1, d2;
        for (int e = 0; e < V; e++) begin
            load(1, e, 32'(e + 1));
            load(2, e, 32'(10 * (e + 1)));
        end
        run_op(3'd0, 1, 1, 2, 3, 0, 0, 0, 0, 0, 0, da1, da2, nd1, nd2, rl1, rl2, e1, e2);
        vectors += 8;
        if (da1 !== 6) begin miscompares++; $display("FAIL add_latency_l1: got %0d want 6", da1); end
        if (da2 !== 4) begin miscompares++; $display("FAIL add_latency_l2: got %0d want 4", da2); end
        if (nd1 !== 1 || nd2 !== 1) begin miscompares++; $display("FAIL add_done_count: got %0d/%0d want 1/1", nd1, nd2); end
        if (rl1 !== 6) begin miscompares++; $display("FAIL add_ready_low_l1: got %0d want 6", rl1); end
        if (rl2 !== 4) begin miscompares++; $display("FAIL add_ready_low_l2: got %0d want 4", rl2); end
        if (e1 !== 1'b0 || e2 !== 1'b0) begin miscompares++; $display("FAIL add_err: got %b/%b want 0/0", e1, e2); end
        if (b1.ready !== 1'b1) begin miscompares++; $display("FAIL add_ready_after_l1: got %b want 1", b1.ready); end
        if (b2.ready !== 1'b1) begin miscompares++; $display("FAIL add_ready_after_l2: got %b want 1", b2.ready); end
        for (int e = 0; e < V; e++) begin
            peek(3, e, d1, d2);
            vectors += 2;
            if (d1 !== 32'(11 * (e + 1))) begin miscompares++; $display("FAIL add_v3_l1[%0d]: got %0d want %0d", e, d1, 11 * (e + 1)); end
            if (d2 !== 32'(11 * (e + 1))) begin miscompares++; $display("FAIL add_v3_l2[%0d]: got %0d want %0d", e, d2, 11 * (e + 1)); end
        end
    endtask

    task automatic test_sub_scalar();
        int da1, da2, nd1, nd2, rl1, rl2;
        logic e1, e2;
        logic [31:0] d1, d2;
        logic [31:0] want [V];
        want = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'd0, 32'd1, 32'd2};
        run_op(3'd1, 0, 1, 0, 1, 32'd3, 0, 0, 0, 0, 0, da1, da2, nd1, nd2, rl1, rl2, e1, e2);
        vectors += 3;
        if (da1 !== 6) begin miscompares++; $display("FAIL sub_latency_l1: got %0d want 6", da1); end
        if (da2 !== 4) begin miscompares++; $display("FAIL sub_latency_l2: got %0d want 4", da2); end
        if (nd1 !== 1 || nd2 !== 1) begin miscompares++; $display("FAIL sub_done_count: got %0d/%0d want 1/1", nd1, nd2); end
        for (int r = 0; r < NV; r++) for (int e = 0; e < V; e++) begin
            peek(r, e, d1, d2);
            vectors += 2;
            if (d1 !== mem[r][e]) begin miscompares++; $display("FAIL sub_vrf_l1 v%0d[%0d]: got %h want %h", r, e, d1, mem[r][e]); end
            if (d2 !== mem[r][e]) begin miscompares++; $display("FAIL sub_vrf_l2 v%0d[%0d]: got %h want %h", r, e, d2, mem[r][e]); end
            if (r == 1) begin
                vectors++;
                if (d2 !== want[e]) begin miscompares++; $display("FAIL sub_v1_const[%0d]: got %h want %h", e, d2, want[e]); end
            end
        end
    endtask

    task automatic test_redsum();
        int da1, da2, nd1, nd2, rl1, rl2;
        logic e1, e2;
        logic [31:0] d1, d2;
        run_op(3'd4, 0, 2, 0, 3, 0, 0, 0, 0, 0, 0, da1, da2, nd1, nd2, rl1, rl2, e1, e2);
        vectors += 4;
        if (b1.red_result !== 32'd150) begin miscompares++; $display("FAIL redsum_l1: got %0d want 150", b1.red_result); end
        if (b2.red_result !== 32'd150) begin miscompares++; $display("FAIL redsum_l2: got %0d want 150", b2.red_result); end
        if (da1 !== 6 || da2 !== 4) begin miscompares++; $display("FAIL redsum_latency: got %0d/%0d want 6/4", da1, da2); end
        if (red_m !== 32'd150) begin miscompares++; $display("FAIL redsum_model: got %0d want 150", red_m); end
        for (int e = 0; e < V; e++) begin
            peek(3, e, d1, d2);
            vectors += 2;
            if (d1 !== mem[3][e]) begin miscompares++; $display("FAIL redsum_v3_l1[%0d]: got %h want %h", e, d1, mem[3][e]); end
            if (d2 !== mem[3][e]) begin miscompares++; $display("FAIL redsum_v3_l2[%0d]: got %h want %h", e, d2, mem[3][e]); end
        end
        for (int e = 0; e < V; e++) load(4, e, 32'hFFFFFFFF);
        run_op(3'd4, 1, 4, 2, 0, 0, 0, 0, 0, 0, 0, da1, da2, nd1, nd2, rl1, rl2, e1, e2);
        vectors += 2;
        if (b1.red_result !== 32'hFFFFFFFB) begin miscompares++; $display("FAIL redsum_wrap_l1: got %h want fffffffb", b1.red_result); end
        if (b2.red_result !== 32'hFFFFFFFB) begin miscompares++; $display("FAIL redsum_wrap_l2: got %h want fffffffb", b2.red_result); end
    endtask

    task automatic test_reserved_and_busy();
        int da1, da2, nd1, nd2, rl1, rl2;
        logic e1, e2;
        logic [31:0] d1, d2;
        run_op(3'd6, 1, 1, 2, 7, 32'h55, 0, 0, 0, 0, 0, da1, da2, nd1, nd2, rl1, rl2, e1, e2);
        vectors += 5;
        if (da1 !== 1 || da2 !== 1) begin miscompares++; $display("FAIL rsv_latency: got %0d/%0d want 1/1", da1, da2); end
        if (e1 !== 1'b1 || e2 !== 1'b1) begin miscompares++; $display("FAIL rsv_err: got %b/%b want 1/1", e1, e2); end
        if (nd1 !== 1 || nd2 !== 1) begin miscompares++; $display("FAIL rsv_done_count: got %0d/%0d want 1/1", nd1, nd2); end
        if (rl1 !== 1 || rl2 !== 1) begin miscompares++; $display("FAIL rsv_ready_low: got %0d/%0d want 1/1", rl1, rl2); end
        if (b1.red_result !== red_m) begin miscompares++; $display("FAIL rsv_red_hold: got %h want %h", b1.red_result, red_m); end
        run_op(3'd3, 1, 1, 2, 5, 0, 0, 0, 0, 0, 1, da1, da2, nd1, nd2, rl1, rl2, e1, e2);
        vectors += 3;
        if (da1 !== 6 || da2 !== 4) begin miscompares++; $display("FAIL busy_latency: got %0d/%0d want 6/4", da1, da2); end
        if (nd1 !== 1 || nd2 !== 1) begin miscompares++; $display("FAIL busy_done_count: got %0d/%0d want 1/1", nd1, nd2); end
        if (e1 !== 1'b0 || e2 !== 1'b0) begin miscompares++; $display("FAIL busy_err: got %b/%b want 0/0", e1, e2); end
        for (int r = 0; r < NV; r++) for (int e = 0; e < V; e++) begin
            peek(r, e, d1, d2);
            vectors += 2;
            if (d1 !== mem[r][e]) begin miscompares++; $display("FAIL busy_vrf_l1 v%0d[%0d]: got %h want %h", r, e, d1, mem[r][e]); end
            if (d2 !== mem[r][e]) begin miscompares++; $display("FAIL busy_vrf_l2 v%0d[%0d]: got %h want %h", r, e, d2, mem[r][e]); end
        end
    endtask

    task automatic test_ld_with_start();
        int da1, da2, nd1, nd2, rl1, rl2;
        logic e1, e2;
        logic [31:0] d1, d2;
        run_op(3'd0, 0, 1, 0, 6, 32'd1, 1, 1, 0, 32'd100, 0, da1, da2, nd1, nd2, rl1, rl2, e1, e2);
        peek(6, 0, d1, d2);
        vectors += 3;
        if (d1 !== 32'd101) begin miscompares++; $display("FAIL ldstart_l1: got %0d want 101", d1); end
        if (d2 !== 32'd101) begin miscompares++; $display("FAIL ldstart_l2: got %0d want 101", d2); end
        if (da1 !== 6 || da2 !== 4) begin miscompares++; $display("FAIL ldstart_latency: got %0d/%0d want 6/4", da1, da2); end
    endtask

    task automatic test_random();
        int da1, da2, nd1, nd2, rl1, rl2, lat1, lat2;
        logic e1, e2;
        logic [31:0] d1, d2;
        logic [2:0] op;
        for (int t = 0; t < 25; t++) begin
            for (int k = 0; k < 3; k++) load($urandom_range(0, NV - 1), $urandom_range(0, 7), $urandom);
            op = 3'($urandom_range(0, 7));
            run_op(op, 1'($urandom_range(0, 1)), $urandom_range(0, NV - 1), $urandom_range(0, NV - 1),
                   $urandom_range(0, NV - 1), $urandom, 0, 0, 0, 0, 0,
                   da1, da2, nd1, nd2, rl1, rl2, e1, e2);
            lat1 = (op > 3'd4) ? 1 : V + 1;
            lat2 = (op > 3'd4) ? 1 : (V + 1) / 2 + 1;
            vectors += 5;
            if (da1 !== lat1 || da2 !== lat2) begin miscompares++; $display("FAIL rnd%0d_latency op%0d: got %0d/%0d want %0d/%0d", t, op, da1, da2, lat1, lat2); end
            if (nd1 !== 1 || nd2 !== 1) begin miscompares++; $display("FAIL rnd%0d_done_count: got %0d/%0d want 1/1", t, nd1, nd2); end
            if (e1 !== (op > 3'd4) || e2 !== (op > 3'd4)) begin miscompares++; $display("FAIL rnd%0d_err: got %b/%b want %b", t, e1, e2, op > 3'd4); end
            if (b1.red_result !== red_m) begin miscompares++; $display("FAIL rnd%0d_red_l1: got %h want %h", t, b1.red_result, red_m); end
            if (b2.red_result !== red_m) begin miscompares++; $display("FAIL rnd%0d_red_l2: got %h want %h", t, b2.red_result, red_m); end
            for (int r = 0; r < NV; r++) for (int e = 0; e < V; e++) begin
                peek(r, e, d1, d2);
                vectors += 2;
                if (d1 !== mem[r][e]) begin miscompares++; $display("FAIL rnd%0d_vrf_l1 v%0d[%0d]: got %h want %h", t, r, e, d1, mem[r][e]); end
                if (d2 !== mem[r][e]) begin miscompares++; $display("FAIL rnd%0d_vrf_l2 v%0d[%0d]: got %h want %h", t, r, e, d2, mem[r][e]); end
            end
        end
    endtask

    task automatic test_reset_midop();
        int ndone;
        logic [31:0] d1, d2;
        ndone = 0;
        @(negedge clk);
        b1.op = 3'd0; b1.vv = 1; b1.vs1 = 4'd1; b1.vs2 = 4'd2; b1.vd = 4'd3; b1.start = 1;
        @(posedge clk);
        #1;
        b1.start = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 0;
        model_clear();
        #1;
        vectors += 2;
        if (b1.ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready_l1: got %b want 1", b1.ready); end
        if (b2.ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready_l2: got %b want 1", b2.ready); end
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (n == 2) rst_n = 1;
            if (b1.done || b2.done) ndone++;
        end
        vectors += 2;
        if (ndone !== 0) begin miscompares++; $display("FAIL midrst_done: got %0d pulses want 0", ndone); end
        if (b2.red_result !== 32'd0) begin miscompares++; $display("FAIL midrst_red: got %h want 0", b2.red_result); end
        for (int r = 0; r < NV; r++) for (int e = 0; e < V; e++) begin
            peek(r, e, d1, d2);
            vectors += 2;
            if (d1 !== mem[r][e]) begin miscompares++; $display("FAIL midrst_vrf_l1 v%0d[%0d]: got %h want %h", r, e, d1, mem[r][e]); end
            if (d2 !== mem[r][e]) begin miscompares++; $display("FAIL midrst_vrf_l2 v%0d[%0d]: got %h want %h", r, e, d2, mem[r][e]); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_scalar();
        test_redsum();
        test_reserved_and_busy();
        test_ld_with_start();
        test_random();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
